// File: rtl/video_scandbl_pkg.sv
// Shared constants for the scan doubler and its line buffer.
// Pure declarations: no logic, no latency, no flow control.
package video_scandbl_pkg;

    localparam int PIX_W     = 15;
    localparam int LINE_W    = 360;
    localparam int BUF_AW    = 10;
    localparam int HBLNK_END = 88;

endpackage

// File: rtl/video_linebuf_dp.sv
// Two-bank line buffer: one write port, one registered read port.
// Read data appears one clk after re_i; no backpressure, both ports accept every clk.
module video_linebuf_dp
    import video_scandbl_pkg::*;
#(
    parameter int DW = PIX_W,
    parameter int AW = BUF_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Contents are deliberately not reset; the top masks stale data with blank.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_scandbl.sv
// Scan doubler: stores TV pixels on c3, replays the opposite bank on f1 (VGA) or passes TV through.
// VGA latency 2 clk after f1, TV latency 1 clk after c3; strobe-driven, no backpressure.
module video_scandbl #(
    parameter int PIX_W  = video_scandbl_pkg::PIX_W,
    parameter int LINE_W = video_scandbl_pkg::LINE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c3,
    input  logic             f1,
    input  logic             vga_on,
    input  logic [9:0]       vga_cnt_in,
    input  logic [9:0]       vga_cnt_out,
    input  logic             tv_blank,
    input  logic             vga_blank,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] rgb_out,
    output logic             blank_out,
    output logic             wr_drop
);
    import video_scandbl_pkg::*;

    localparam int               PX_AW    = BUF_AW - 1;
    localparam logic [PX_AW-1:0] LINE_LIM = PX_AW'(LINE_W);

    logic              wr_in_range;
    logic              wr_we;
    logic              rd_oob;
    logic              mode_chg;

    logic [BUF_AW-1:0] rd_addr_q;
    logic              rd_v1_q;
    logic              rd_v2_q;
    logic              bl1_q;
    logic              bl2_q;
    logic              oob2_q;
    logic              vga_on_q;
    logic              wr_drop_q;
    logic              wr_drop_d;
    logic [PIX_W-1:0]  ram_rdata;
    logic [PIX_W-1:0]  rgb_q;
    logic [PIX_W-1:0]  rgb_d;
    logic              blank_q;
    logic              blank_d;

    assign wr_in_range = vga_cnt_in[PX_AW-1:0] < LINE_LIM;
    assign wr_we       = c3 && wr_in_range;
    assign rd_oob      = rd_addr_q[PX_AW-1:0] >= LINE_LIM;
    assign mode_chg    = vga_on != vga_on_q;

    video_linebuf_dp #(
        .DW (PIX_W),
        .AW (BUF_AW)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (wr_we),
        .waddr_i (vga_cnt_in),
        .wdata_i (pix_in),
        .re_i    (rd_v1_q),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

    // Read pipeline: stage 1 holds the address, stage 2 aligns with RAM data.
    // A mode switch forces both blank stages so in-flight reads emerge blanked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rd_v1_q   <= 1'b0;
            rd_v2_q   <= 1'b0;
            bl1_q     <= 1'b1;
            bl2_q     <= 1'b1;
            oob2_q    <= 1'b0;
            vga_on_q  <= vga_on;
        end else begin
            vga_on_q <= vga_on;
            rd_v1_q  <= f1;
            rd_v2_q  <= rd_v1_q;
            if (f1) begin
                rd_addr_q <= vga_cnt_out;
                bl1_q     <= vga_blank | mode_chg;
            end else if (mode_chg) begin
                bl1_q <= 1'b1;
            end
            if (rd_v1_q) begin
                bl2_q  <= bl1_q | mode_chg;
                oob2_q <= rd_oob;
            end else if (mode_chg) begin
                bl2_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rgb_d     = rgb_q;
        blank_d   = blank_q;
        wr_drop_d = wr_drop_q | (c3 & ~tv_blank & ~wr_in_range);
        if (!vga_on) begin
            if (c3) begin
                rgb_d   = tv_blank ? '0 : pix_in;
                blank_d = tv_blank;
            end
        end else if (rd_v2_q) begin
            blank_d = bl2_q | mode_chg;
            rgb_d   = (bl2_q | mode_chg | oob2_q) ? '0 : ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q     <= '0;
            blank_q   <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            blank_q   <= blank_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    assign rgb_out   = rgb_q;
    assign blank_out = blank_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_video_scandbl.sv
// Scoreboard bench for video_scandbl: drivers queue expected outputs with a due cycle,
// a monitor compares them one step after the matching clock edge.
module tb_video_scandbl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c3;
    logic        f1;
    logic        vga_on;
    logic [9:0]  vga_cnt_in;
    logic [9:0]  vga_cnt_out;
    logic        tv_blank;
    logic        vga_blank;
    logic [14:0] pix_in;
    logic [14:0] rgb_out;
    logic        blank_out;
    logic        wr_drop;

    typedef struct {
        int          due;
        logic [14:0] rgb;
        logic        blk;
        logic        drop;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic        exp_drop = 1'b0;
    logic [14:0] last_rgb = '0;
    logic        last_blk = 1'b1;

    video_scandbl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c3          (c3),
        .f1          (f1),
        .vga_on      (vga_on),
        .vga_cnt_in  (vga_cnt_in),
        .vga_cnt_out (vga_cnt_out),
        .tv_blank    (tv_blank),
        .vga_blank   (vga_blank),
        .pix_in      (pix_in),
        .rgb_out     (rgb_out),
        .blank_out   (blank_out),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every entry due at this edge is compared against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.due < cyc) begin
                    errors++;
                    $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.due);
                end else if (rgb_out !== e.rgb || blank_out !== e.blk || wr_drop !== e.drop) begin
                    errors++;
                    $display("FAIL %s: got rgb=%h blank=%b drop=%b, want rgb=%h blank=%b drop=%b",
                             e.name, rgb_out, blank_out, wr_drop, e.rgb, e.blk, e.drop);
                end
            end
        end
    end

    task automatic cyc_drive(input logic c3v, input logic f1v, input logic [9:0] win,
                             input logic [9:0] rd, input logic [14:0] px,
                             input logic tb, input logic vb);
        @(negedge clk);
        c3          = c3v;
        f1          = f1v;
        vga_cnt_in  = win;
        vga_cnt_out = rd;
        pix_in      = px;
        tv_blank    = tb;
        vga_blank   = vb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b0, 10'd0, 10'd0, 15'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input int due, input logic [14:0] r, input logic b, input string nm);
        exp_t e;
        e.due  = due;
        e.rgb  = r;
        e.blk  = b;
        e.drop = exp_drop;
        e.name = nm;
        sb.push_back(e);
        last_rgb = r;
        last_blk = b;
    endtask

    task automatic push_hold(input int due, input string nm);
        push(due, last_rgb, last_blk, nm);
    endtask

    task automatic wr(input logic [9:0] a, input logic [14:0] px, input logic tb);
        cyc_drive(1'b1, 1'b0, a, 10'd0, px, tb, 1'b0);
    endtask

    // VGA read: result due 2 clk after the strobe edge, then must hold one more clk.
    task automatic rd(input logic [9:0] a, input logic vb, input logic [14:0] d, input string nm);
        logic [14:0] r;
        cyc_drive(1'b0, 1'b1, 10'd0, a, 15'd0, 1'b0, vb);
        r = vb ? 15'd0 : d;
        push(cyc + 3, r, vb, nm);
        push(cyc + 4, r, vb, {nm, "_hold"});
        cyc_drive(1'b0, 1'b0, 10'd0, a, 15'd0, 1'b0, vb);
    endtask

    task automatic tv(input logic [9:0] a, input logic [14:0] px, input logic tb, input string nm);
        cyc_drive(1'b1, 1'b0, a, 10'd0, px, tb, 1'b0);
        push(cyc + 1, tb ? 15'd0 : px, tb, nm);
        cyc_drive(1'b0, 1'b0, 10'd0, 10'd0, 15'd0, 1'b0, 1'b0);
        push(cyc + 1, tb ? 15'd0 : px, tb, {nm, "_hold"});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        c3          = 1'b0;
        f1          = 1'b0;
        vga_on      = 1'b1;
        vga_cnt_in  = '0;
        vga_cnt_out = '0;
        tv_blank    = 1'b0;
        vga_blank   = 1'b0;
        pix_in      = '0;

        // Reset values while rst_n is held low.
        idle(1);
        push(cyc + 1, 15'd0, 1'b1, "reset_a");
        push(cyc + 2, 15'd0, 1'b1, "reset_b");
        idle(2);
        rst_n = 1'b1;
        drain();

        // Ramp into bank 0, then read it back.
        for (int i = 0; i < 360; i++) wr(10'(i), 15'(i), 1'b0);
        idle(1);
        for (int i = 0; i < 360; i++) rd(10'(i), 1'b0, 15'(i), $sformatf("ramp%0d", i));
        drain();

        // Out-of-range writes: blanked one leaves the flag clear, active one sets it.
        wr(10'h16A, 15'h7777, 1'b1);
        push_hold(cyc + 1, "drop_blanked");
        exp_drop = 1'b1;
        wr(10'h16A, 15'h7777, 1'b0);
        push_hold(cyc + 1, "drop_set");
        idle(5);
        push_hold(cyc + 1, "drop_sticky");
        rd(10'h06A, 1'b0, 15'd106, "no_alias");
        rd(10'h16A, 1'b0, 15'd0, "oob_read");
        drain();

        // Blanked reads over full-scale data, bracketed by unblanked ones.
        for (int i = 0; i < 8; i++) wr(10'h200 + 10'(i), 15'h7FFF, 1'b0);
        idle(1);
        rd(10'h200, 1'b0, 15'h7FFF, "blk_pre");
        for (int i = 0; i < 8; i++) rd(10'h200 + 10'(i), 1'b1, 15'h7FFF, $sformatf("blk%0d", i));
        rd(10'h207, 1'b0, 15'h7FFF, "blk_post");
        drain();

        // Simultaneous write to bank 1 and read from bank 0.
        wr(10'h005, 15'h0ABC, 1'b0);
        cyc_drive(1'b1, 1'b1, 10'h205, 10'h005, 15'h1234, 1'b0, 1'b0);
        push(cyc + 3, 15'h0ABC, 1'b0, "same_clk_rd");
        push(cyc + 4, 15'h0ABC, 1'b0, "same_clk_hold");
        idle(1);
        rd(10'h205, 1'b0, 15'h1234, "same_clk_wr");
        drain();

        // TV passthrough; writes continue and f1 must not disturb the output.
        idle(1);
        vga_on = 1'b0;
        idle(2);
        tv(10'h00A, 15'h2AAA, 1'b0, "tv_pix");
        tv(10'h00B, 15'h2AAA, 1'b1, "tv_blank");
        cyc_drive(1'b0, 1'b1, 10'd0, 10'h003, 15'd0, 1'b0, 1'b0);
        push_hold(cyc + 3, "tv_ignores_f1");
        idle(4);
        drain();
        vga_on = 1'b1;
        idle(3);
        rd(10'h00A, 1'b0, 15'h2AAA, "tv_wr_a");
        rd(10'h00B, 1'b0, 15'h2AAA, "tv_wr_b");
        drain();

        // One-clk reset during readout aborts the pending read.
        cyc_drive(1'b0, 1'b1, 10'd0, 10'd20, 15'd0, 1'b0, 1'b0);
        cyc_drive(1'b0, 1'b0, 10'd0, 10'd0, 15'd0, 1'b0, 1'b0);
        rst_n    = 1'b0;
        exp_drop = 1'b0;
        push(cyc + 1, 15'd0, 1'b1, "rst_mid");
        cyc_drive(1'b0, 1'b0, 10'd0, 10'd0, 15'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        push_hold(cyc + 1, "rst_abort");
        idle(2);
        rd(10'd30, 1'b0, 15'd30, "post_rst");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_scandbl.md
VIDEO_SCANDBL -- requirements
Module: video_scandbl

Interface
REQ-001 Parameter PIX_W, default 15, meaning: pixel width in bits (RGB555).
REQ-002 Parameter LINE_W, default 360, meaning: stored pixels per TV line.
REQ-003 Port clk  in  1  system clock; single clock domain.
REQ-004 Port rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port c3  in  1  7 MHz pixel-write strobe, one clk wide.
REQ-006 Port f1  in  1  14 MHz pixel-read strobe, one clk wide.
REQ-007 Port vga_on  in  1  1 = VGA scan-doubled output; 0 = TV passthrough.
REQ-008 Port vga_cnt_in  in  10  write address {bank, pixel}; pixel = hcount-88, modulo 512.
REQ-009 Port vga_cnt_out  in  10  read address {bank, pixel}; bank is opposite to the write bank.
REQ-010 Port tv_blank  in  1  TV blanking, aligned with pix_in.
REQ-011 Port vga_blank  in  1  VGA blanking, aligned with vga_cnt_out.
REQ-012 Port pix_in  in  PIX_W  rendered TV pixel, valid on c3.
REQ-013 Port rgb_out  out  PIX_W  output pixel; forced to zero while blanked.
REQ-014 Port blank_out  out  1  output blanking, aligned with rgb_out.
REQ-015 Port wr_drop  out  1  sticky flag: a write was discarded because the address was out of range.

Function
REQ-016 Write: on a clk with c3=1 and vga_cnt_in[8:0] < LINE_W, store pix_in at address vga_cnt_in; with vga_cnt_in[8:0] >= LINE_W, perform no write.
REQ-017 wr_drop sets only when c3=1, tv_blank=0 and vga_cnt_in[8:0] >= LINE_W; it clears only on reset.
REQ-018 Read: on a clk with f1=1, register vga_cnt_out; the buffer data for that address is available one clk later.
REQ-019 A registered read address with [8:0] >= LINE_W returns zero, not buffer contents.
REQ-020 VGA path (vga_on=1): the result is registered into rgb_out two clk after the f1 read strobe.
REQ-021 VGA blanking: blank_out carries vga_blank delayed by the same two clk; rgb_out = 0 whenever the delayed blank = 1.
REQ-022 Between f1 strobes, rgb_out and blank_out hold their values.
REQ-023 TV path (vga_on=0): on c3, rgb_out <= (tv_blank ? 0 : pix_in) and blank_out <= tv_blank, so latency is one clk; line-buffer writes continue.
REQ-024 Changing vga_on takes effect on the next applicable strobe; the two-stage VGA pipeline is flushed to blank (rgb_out=0, blank_out=1) for its two stages.
REQ-025 c3 and f1 in the same clk: the write and the read both execute. No write-read conflict can occur, because the two banks differ.
REQ-026 Boundary: bank toggling is owned upstream. The block stores no line-parity state; a mid-line parity change only redirects subsequent writes.
REQ-027 Buffer depth is 2*512 words of PIX_W bits, addressed directly by the 10-bit counters with no arithmetic.

Reset
REQ-028 While rst_n=0 at a clk edge: rgb_out=0, blank_out=1, wr_drop=0, pipeline valid/blank stages=blank, registered read address=0.
REQ-029 Buffer contents are not reset; after reset, output is undefined-data-free only because the blank stages force zero until the first full pipeline fill.
REQ-030 Reset asserted mid-line aborts any pending read; the first post-reset output appears two clk after the first f1 strobe.

Structure
REQ-031 The shared video package holds PIX_W, LINE_W, the buffer address width (10) and the HBLNK_END offset constant (88).
REQ-032 A single sub-module, video_linebuf_dp (simple dual-port RAM, one write port, one registered read port, 1024xPIX_W), is instantiated once.
REQ-033 All remaining logic (gating, pipeline, mux, flag) is in video_scandbl; the target size is 120-400 RTL lines.

Verification
REQ-034 vga_on=1, write ramp pix_in=addr at c3 into bank 0, addresses 0..359, then read bank 0 at f1 -> rgb_out equals the address sequence 0..359, each value appearing two clk after its f1 strobe.
REQ-035 Write at vga_cnt_in=10'h16A (pixel 362) with tv_blank=0 -> no RAM change; wr_drop=1 and stays 1 until rst_n=0.
REQ-036 vga_blank=1 for 8 reads over stored data 15'h7FFF -> rgb_out=0 and blank_out=1 for exactly those 8 output slots.
REQ-037 c3 and f1 in the same clk: write 15'h1234 to bank 1, addr 5; read bank 0, addr 5 (holding 15'h0ABC) -> output 15'h0ABC, and bank 1 addr 5 = 15'h1234 on a later read.
REQ-038 vga_on=0, pix_in=15'h2AAA, tv_blank=0 on c3 -> rgb_out=15'h2AAA one clk later; with tv_blank=1 -> rgb_out=0, blank_out=1.
REQ-039 rst_n=0 for one clk during active VGA readout -> the next clk shows rgb_out=0, blank_out=1, wr_drop=0; valid data resumes two clk after the next f1.
